mux16_rr_arbiter: RTL and testbench
===================================

// Module: mux16_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one mux_16 datapath between 16 requesters.
//  - Drives the mux select and captures the mux output into a registered
//    valid/ready output stage.
//  - Sits between 16 producer ports and a single downstream consumer.
//  - Sustains one transfer per cycle when the consumer is always ready.
// PARAMETERS
//  WIDTH       32  data width of each mux_16 input and of out_data
//  FIXED_PRIO  0   0: round-robin; 1: fixed priority, index 0 highest
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  req        in   16     req[i]=1: requester i holds valid data on mux input d<i>
//  arb_en     in   1      0: no new grants issued; pending output still drains
//  mux_sel    out  4      select to the external mux_16 s port
//  mux_y      in   WIDTH  y output of the external mux_16
//  gnt        out  16     one-hot, 1-cycle pulse: requester i's data is taken
//  out_valid  out  1      output register holds a transfer
//  out_ready  in   1      consumer accepts when out_valid & out_ready
//  out_data   out  WIDTH  captured mux_y
//  out_src    out  4      index of the requester that produced out_data
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, out_data=0, out_src=0,
//    ptr=4'd15, so index 0 has priority first.
//  - During reset: gnt=0 and mux_sel=ptr=15.
//  - slot_free = !out_valid | out_ready. A grant is issued in a cycle iff
//    slot_free & arb_en & |req.
//  - Winner (RR): first set req bit scanning ptr+1, ptr+2, ... modulo 16.
//    Wrap-around: ptr=15 scans from 0.
//  - Winner (FIXED_PRIO=1): lowest set index; ptr is unused.
//  - Grant cycle, combinational: mux_sel=winner and gnt[winner]=1.
//  - Grant cycle, on the edge: out_data<=mux_y, out_src<=winner, out_valid<=1,
//    ptr<=winner.
//  - No grant in the cycle:
//    - gnt=0 and mux_sel=ptr (stable, no toggling).
//    - If out_valid & out_ready, then out_valid<=0; out_data/out_src hold.
//  - Latency: req asserted in cycle N with a free slot -> out_valid=1 in N+1.
//    Back-to-back grants are allowed when out_ready=1.
//  - Full (out_valid & !out_ready): no grant; out_data, out_src and out_valid
//    hold; all requesters wait.
//  - Simultaneous drain and grant: the new data replaces the old in the same
//    edge and out_valid stays 1.
//  - Requester protocol: hold req and d<i> stable until gnt[i].
//    - req may drop only when gnt[i] is high or when it was never granted.
//    - Deasserting req without a grant is legal and not an error.
//  - Single requester: granted every cycle the slot is free, and ptr stays on
//    it. No fairness penalty.
//  - arb_en dropping: takes effect the same cycle; no grant that cycle.
//  - Reset mid-transfer: the pending output is discarded (out_valid->0
//    immediately) and ptr returns to 15.
//  - gnt is always one-hot or zero. out_src always equals the index whose
//    gnt pulsed on the capturing edge.
// TESTING
//  1. After reset: req=16'hFFFF, out_ready=1 ->
//     - gnt sequence 0,1,2,...,15,0, one per cycle.
//     - out_src follows one cycle later and out_data=d<out_src>.
//  2. Only req[5] and req[3] set, ptr=15 -> grants 3,5,3,5 (wrap-around).
//     With FIXED_PRIO=1 -> 3,3,3 while req[3] stays high.
//  3. out_ready=0 after the first grant ->
//     - out_valid stays 1 and out_data/out_src hold.
//     - gnt=0 for 10 cycles.
//     - out_ready=1 -> drain and new grant on the same edge.
//  4. arb_en=0 with req=16'h0010 -> no gnt and out_valid falls after drain;
//     arb_en=1 -> gnt[4] next cycle.
//  5. rst_n asserted asynchronously while out_valid=1 ->
//     - out_valid=0 without a clock edge.
//     - The first grant after release goes to the lowest active index.
//  6. Random req/out_ready, 10k cycles ->
//     - no lost or duplicated transfers (scoreboard per gnt).
//     - gnt one-hot or zero.
//     - No requester waits more than 16 grants (RR).

Source files
------------

// File: rtl/mux16_rr_arbiter_if.sv
// Bus bundle between 16 producers, the external mux_16 and one consumer.
// The arbiter takes the slave view; the surrounding environment the master.
interface mux16_rr_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [15:0]      req;
  logic             arb_en;
  logic [3:0]       mux_sel;
  logic [WIDTH-1:0] mux_y;
  logic [15:0]      gnt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       out_src;

  modport slave (
    input  req, arb_en, mux_y, out_ready,
    output mux_sel, gnt, out_valid, out_data, out_src
  );

  modport master (
    output req, arb_en, mux_y, out_ready,
    input  mux_sel, gnt, out_valid, out_data, out_src
  );
endinterface

// File: rtl/mux16_rr_arbiter.sv
// Round-robin (or fixed-priority) arbiter steering an external mux_16 and
// capturing its output into a one-deep valid/ready output register.
module mux16_rr_arbiter #(
  parameter int WIDTH      = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  mux16_rr_arbiter_if.slave bus
);

  logic [3:0]       ptr;
  logic [3:0]       winner;
  logic [3:0]       cand;
  logic             found;
  logic             slot_free;
  logic             grant;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [3:0]       out_src_q;

  // Scan in reverse so the last hit written is the first in priority order.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can leave it unassigned and infer a latch.
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    if (FIXED_PRIO) begin
      for (int i = 15; i >= 0; i--) begin
        if (bus.req[i]) begin
          winner = 4'(i);
          found  = 1'b1;
        end
      end
    end else begin
      for (int k = 16; k >= 1; k--) begin
        cand = ptr + 4'(k);
        if (bus.req[cand]) begin
          winner = cand;
          found  = 1'b1;
        end
      end
    end
  end

  assign slot_free   = !out_valid_q || bus.out_ready;
  // rst_n gates the grant so nothing pulses while reset is held.
  assign grant       = rst_n && slot_free && bus.arb_en && found;

  assign bus.gnt     = grant ? (16'd1 << winner) : 16'd0;
  assign bus.mux_sel = grant ? winner : ptr;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      ptr         <= 4'd15;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else if (grant) begin
      ptr         <= winner;
      out_valid_q <= 1'b1;
      out_data_q  <= bus.mux_y;
      out_src_q   <= winner;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority arbiter share the
// same stimulus and are checked every cycle against a behavioural model.
module tb_mux16_rr_arbiter;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic [15:0]      req;
  logic             arb_en;
  logic             out_ready;
  logic [WIDTH-1:0] d [16];

  int n_checks;
  int n_fail;

  mux16_rr_arbiter_if #(.WIDTH(WIDTH)) bus_rr ();
  mux16_rr_arbiter_if #(.WIDTH(WIDTH)) bus_fp ();

  assign bus_rr.req       = req;
  assign bus_rr.arb_en    = arb_en;
  assign bus_rr.out_ready = out_ready;
  assign bus_rr.mux_y     = d[bus_rr.mux_sel];
  assign bus_fp.req       = req;
  assign bus_fp.arb_en    = arb_en;
  assign bus_fp.out_ready = out_ready;
  assign bus_fp.mux_y     = d[bus_fp.mux_sel];

  mux16_rr_arbiter #(.WIDTH(WIDTH), .FIXED_PRIO(1'b0)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_rr)
  );

  mux16_rr_arbiter #(.WIDTH(WIDTH), .FIXED_PRIO(1'b1)) u_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_fp)
  );

  logic [15:0]      act_gnt   [2];
  logic [3:0]       act_sel   [2];
  logic             act_valid [2];
  logic [WIDTH-1:0] act_data  [2];
  logic [3:0]       act_src   [2];

  assign act_gnt[0]   = bus_rr.gnt;
  assign act_sel[0]   = bus_rr.mux_sel;
  assign act_valid[0] = bus_rr.out_valid;
  assign act_data[0]  = bus_rr.out_data;
  assign act_src[0]   = bus_rr.out_src;
  assign act_gnt[1]   = bus_fp.gnt;
  assign act_sel[1]   = bus_fp.mux_sel;
  assign act_valid[1] = bus_fp.out_valid;
  assign act_data[1]  = bus_fp.out_data;
  assign act_src[1]   = bus_fp.out_src;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int inst,
                       input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic             m_valid [2];
  logic [WIDTH-1:0] m_data  [2];
  logic [3:0]       m_ptr   [2];
  logic [3:0]       m_src   [2];

  // Winner index if a grant happens this cycle, else -1.
  function automatic int model_win(input int n);
    int w;
    w = -1;
    if (!(arb_en && (!m_valid[n] || out_ready))) return -1;
    if (n == 1) begin
      for (int i = 15; i >= 0; i--) if (req[i]) w = i;
    end else begin
      for (int k = 16; k >= 1; k--) if (req[(int'(m_ptr[n]) + k) % 16]) w = (int'(m_ptr[n]) + k) % 16;
    end
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int n = 0; n < 2; n++) begin
      if (!rst_n) begin
        m_valid[n] <= 1'b0;
        m_data[n]  <= '0;
        m_src[n]   <= 4'd0;
        m_ptr[n]   <= 4'd15;
      end else if (model_win(n) >= 0) begin
        m_valid[n] <= 1'b1;
        m_data[n]  <= d[model_win(n)];
        m_src[n]   <= 4'(model_win(n));
        m_ptr[n]   <= 4'(model_win(n));
      end else if (out_ready) begin
        m_valid[n] <= 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [15:0] last_gnt_rr;
  bit          rnd_phase;
  int          gnt_cnt [2];
  int          acc_cnt [2];
  int          waits   [16];
  int          max_wait;

  initial begin
    last_gnt_rr = '0;
    rnd_phase   = 1'b0;
  end

  always @(negedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (rst_n && model_win(n) >= 0) begin
        check("gnt", n, act_gnt[n], 16'd1 << model_win(n));
        check("mux_sel", n, act_sel[n], model_win(n));
      end else begin
        check("gnt", n, act_gnt[n], 16'd0);
        check("mux_sel", n, act_sel[n], m_ptr[n]);
      end
      check("out_valid", n, act_valid[n], m_valid[n]);
      check("out_data", n, act_data[n], m_data[n]);
      check("out_src", n, act_src[n], m_src[n]);
      check("gnt_onehot0", n, $onehot0(act_gnt[n]), 1);
      if (rnd_phase) begin
        if (act_gnt[n] != 16'd0) gnt_cnt[n]++;
        if (act_valid[n] && out_ready) acc_cnt[n]++;
      end
    end
    last_gnt_rr = act_gnt[0];
    if (rnd_phase) begin
      max_wait = 0;
      for (int i = 0; i < 16; i++) begin
        if (act_gnt[0][i] || !req[i]) waits[i] = 0;
        else if (act_gnt[0] != 16'd0) waits[i]++;
        if (waits[i] > max_wait) max_wait = waits[i];
      end
      if (act_gnt[0] != 16'd0) check("rr_max_wait_le15", 0, (max_wait <= 15), 1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req       = '0;
    arb_en    = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) d[i] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 16; i++) waits[i] = 0;
    for (int n = 0; n < 2; n++) begin
      gnt_cnt[n] = 0;
      acc_cnt[n] = 0;
    end

    // 1: all requesting -> RR walks 0..15,0; fixed always picks 0
    do_reset();
    req = 16'hFFFF;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      check("t1_gnt_rr", 0, act_gnt[0], 16'd1 << (k % 16));
      check("t1_gnt_fp", 1, act_gnt[1], 16'h0001);
      if (k >= 1) begin
        check("t1_src_rr", 0, act_src[0], (k - 1) % 16);
        check("t1_data_rr", 0, act_data[0], d[(k - 1) % 16]);
        check("t1_src_fp", 1, act_src[1], 0);
      end
      next_cycle();
    end

    // 2: req 3 and 5 -> RR alternates 3,5; fixed stays on 3
    do_reset();
    req = 16'h0028;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t2_gnt_rr", 0, act_gnt[0], (k % 2 == 0) ? 16'h0008 : 16'h0020);
      check("t2_gnt_fp", 1, act_gnt[1], 16'h0008);
      next_cycle();
    end

    // 3: consumer stalls after the first grant, then drains and regrants
    do_reset();
    req = 16'h0028;
    @(negedge clk);
    check("t3_first_gnt", 0, act_gnt[0], 16'h0008);
    next_cycle();
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t3_stall_gnt", 0, act_gnt[0], 16'h0000);
      check("t3_stall_valid", 0, act_valid[0], 1);
      check("t3_stall_src", 0, act_src[0], 3);
      check("t3_stall_data", 0, act_data[0], 32'hA000_0003);
      next_cycle();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_regrant", 0, act_gnt[0], 16'h0020);
    next_cycle();
    @(negedge clk);
    check("t3_new_src", 0, act_src[0], 5);
    check("t3_new_valid", 0, act_valid[0], 1);

    // 4: arbitration disabled drains the output; re-enable grants requester 4
    next_cycle();
    arb_en = 1'b0;
    req    = 16'h0010;
    @(negedge clk);
    check("t4_off_gnt", 0, act_gnt[0], 16'h0000);
    next_cycle();
    @(negedge clk);
    check("t4_drained", 0, act_valid[0], 0);
    check("t4_off_gnt2", 1, act_gnt[1], 16'h0000);
    next_cycle();
    arb_en = 1'b1;
    @(negedge clk);
    check("t4_on_gnt", 0, act_gnt[0], 16'h0010);
    next_cycle();
    check("t4_valid", 0, act_valid[0], 1);

    // 5: asynchronous reset mid-cycle clears the output without a clock edge
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_valid_rr", 0, act_valid[0], 0);
    check("t5_async_valid_fp", 1, act_valid[1], 0);
    check("t5_async_gnt", 0, act_gnt[0], 16'h0000);
    check("t5_async_sel", 0, act_sel[0], 15);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req   = 16'h0050;
    @(negedge clk);
    check("t5_first_gnt_rr", 0, act_gnt[0], 16'h0010);
    check("t5_first_gnt_fp", 1, act_gnt[1], 16'h0010);

    // 6: random traffic checked by the model, scoreboard counts and fairness
    do_reset();
    req       = '0;
    rnd_phase = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 16; i++) begin
        if (last_gnt_rr[i]) begin
          d[i]   = $urandom;
          req[i] = 1'($urandom_range(0, 1));
        end else if (!req[i]) begin
          req[i] = ($urandom_range(0, 3) == 0);
        end else if ($urandom_range(0, 63) == 0) begin
          req[i] = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      arb_en    = ($urandom_range(0, 15) != 0);
      next_cycle();
    end
    req       = '0;
    arb_en    = 1'b0;
    out_ready = 1'b1;
    repeat (3) next_cycle();
    rnd_phase = 1'b0;
    for (int n = 0; n < 2; n++) begin
      check("xfer_count", n, gnt_cnt[n], acc_cnt[n]);
      check("final_drained", n, act_valid[n], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
